rf_wr_arbiter: RTL and testbench

//  Sequences and shares the single write port of the 8-entry register file
//  (an array of 16-bit enabled registers) between two writeback requesters.

---
 rtl/rf_wr_arbiter_if.sv | 33 +++
 rtl/rf_wr_arbiter.sv | 88 ++++++++
 tb/tb_rf_wr_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_wr_arbiter_if.sv
// Write-port bundle between the two writeback requesters and the register-file
// write arbiter: request handshakes, clear request and the registered write port.
interface rf_wr_arbiter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8,
  parameter int unsigned AW    = 3
);
  logic             clr_req;
  logic             v0;
  logic [AW-1:0]    addr0;
  logic [WIDTH-1:0] data0;
  logic             rdy0;
  logic             v1;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] data1;
  logic             rdy1;
  logic [NREG-1:0]  wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             init_done;
  logic             last_gnt;

  // Requester/register-file side.
  modport master (
    output clr_req, v0, addr0, data0, v1, addr1, data1,
    input  rdy0, rdy1, wr_sel, wr_data, init_done, last_gnt
  );

  // Arbiter side.
  modport slave (
    input  clr_req, v0, addr0, data0, v1, addr1, data1,
    output rdy0, rdy1, wr_sel, wr_data, init_done, last_gnt
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Shares the single register-file write port between ALU writeback (req 0) and
// load writeback (req 1), after zeroing every register on reset or clear.
module rf_wr_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8,
  parameter int unsigned AW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  rf_wr_arbiter_if.slave bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;

  // Round-robin accept: on contention the requester that did not win last time goes.
  always_comb begin
    bus.rdy0 = 1'b0;
    bus.rdy1 = 1'b0;
    if (!rst && (state == ST_RUN) && !bus.clr_req) begin
      if (bus.v0 && bus.v1) begin
        bus.rdy0 = bus.last_gnt;
        bus.rdy1 = !bus.last_gnt;
      end else begin
        bus.rdy0 = bus.v0;
        bus.rdy1 = bus.v1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INIT;
      cnt           <= '0;
      bus.wr_sel    <= '0;
      bus.wr_data   <= '0;
      bus.init_done <= 1'b0;
      bus.last_gnt  <= 1'b1;
    end else begin
      case (state)
        // Walk every register writing zero; the last one hands over to RUN.
        ST_INIT: begin
          bus.wr_sel  <= NREG'(1) << cnt;
          bus.wr_data <= '0;
          if (cnt == LAST_IDX) begin
            state         <= ST_RUN;
            cnt           <= '0;
            bus.init_done <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        ST_RUN: begin
          if (bus.clr_req) begin
            state         <= ST_INIT;
            cnt           <= '0;
            bus.init_done <= 1'b0;
            bus.wr_sel    <= '0;
          end else if (bus.rdy0) begin
            bus.wr_sel   <= NREG'(1) << bus.addr0;
            bus.wr_data  <= bus.data0;
            bus.last_gnt <= 1'b0;
          end else if (bus.rdy1) begin
            bus.wr_sel   <= NREG'(1) << bus.addr1;
            bus.wr_data  <= bus.data1;
            bus.last_gnt <= 1'b1;
          end else begin
            bus.wr_sel <= '0;
          end
        end
      endcase
    end
  end

  // Structural invariants of the write port and handshake.
  a_sel_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.wr_sel));
  a_rdy_excl   : assert property (@(posedge clk) disable iff (rst) !(bus.rdy0 && bus.rdy1));
  a_rdy0_valid : assert property (@(posedge clk) disable iff (rst) bus.rdy0 |-> bus.v0);
  a_rdy1_valid : assert property (@(posedge clk) disable iff (rst) bus.rdy1 |-> bus.v1);

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: init sequence, single and contended grants,
// same-address ordering, clear re-init and reset mid-INIT / mid-grant.
module tb_rf_wr_arbiter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREG  = 8;
  localparam int unsigned AW    = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [WIDTH-1:0] regs [NREG];

  rf_wr_arbiter_if #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) bus ();

  rf_wr_arbiter #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model fed only by the write port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NREG); i++)
      if (bus.wr_sel[i]) regs[i] <= bus.wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr_req = 1'b0;
    bus.v0 = 1'b0; bus.addr0 = '0; bus.data0 = '0;
    bus.v1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
  endtask

  // Called just after the edge that starts INIT (cnt=0, wr_sel=0); ends at negedge of cycle 8.
  task automatic init_seq(input logic exp_rdy0_last);
    logic [7:0] one;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      one = 8'h01;
      chk($sformatf("init_sel%0d", k), 32'(bus.wr_sel), (k == 0) ? 32'h0 : 32'(one << (k - 1)));
      if (k > 0) chk($sformatf("init_data%0d", k), 32'(bus.wr_data), 32'h0);
      chk($sformatf("init_done%0d", k), 32'(bus.init_done), (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("init_rdy0_%0d", k), 32'(bus.rdy0), (k == 8) ? 32'(exp_rdy0_last) : 32'h0);
      chk($sformatf("init_rdy1_%0d", k), 32'(bus.rdy1), 32'h0);
      if (k < 8) cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    rst = 1'b1;
    bus.v0 = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_sel", 32'(bus.wr_sel), 32'h0);
    chk("rst_data", 32'(bus.wr_data), 32'h0);
    chk("rst_done", 32'(bus.init_done), 32'h0);
    chk("rst_last", 32'(bus.last_gnt), 32'h1);
    chk("rst_rdy0", 32'(bus.rdy0), 32'h0);

    // Init sequence with a request from req 0 waiting; accepted in cycle 8.
    cyc();
    rst = 1'b0;
    bus.v0 = 1'b1; bus.addr0 = 3'd3; bus.data0 = 16'hBEEF;
    init_seq(1'b1);
    cyc();
    bus.v0 = 1'b0;
    @(negedge clk);
    chk("s2_sel", 32'(bus.wr_sel), 32'h08);
    chk("s2_data", 32'(bus.wr_data), 32'hBEEF);
    chk("s2_last", 32'(bus.last_gnt), 32'h0);
    cyc();
    @(negedge clk);
    chk("s2_reg3", 32'(regs[3]), 32'hBEEF);
    chk("s2_idle_sel", 32'(bus.wr_sel), 32'h0);
    chk("s2_hold_data", 32'(bus.wr_data), 32'hBEEF);

    // Fresh reset so last_gnt=1, then both requesters contend for 4 cycles.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    init_seq(1'b0);
    chk("s3_last0", 32'(bus.last_gnt), 32'h1);
    cyc();
    bus.v0 = 1'b1; bus.addr0 = 3'd1; bus.data0 = 16'h00A0;
    bus.v1 = 1'b1; bus.addr1 = 3'd2; bus.data1 = 16'h00B0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("s3_rdy0_%0d", j), 32'(bus.rdy0), (j % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("s3_rdy1_%0d", j), 32'(bus.rdy1), (j % 2 == 1) ? 32'h1 : 32'h0);
      chk($sformatf("s3_sel%0d", j), 32'(bus.wr_sel),
          (j == 0) ? 32'h0 : ((j % 2 == 1) ? 32'h02 : 32'h04));
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    chk("s3_sel_end", 32'(bus.wr_sel), 32'h04);
    chk("s3_data_end", 32'(bus.wr_data), 32'h00B0);
    chk("s3_last_end", 32'(bus.last_gnt), 32'h1);

    // One grant to req 0 leaves last_gnt=0; then both hit register 5.
    cyc();
    bus.v0 = 1'b1; bus.addr0 = 3'd0; bus.data0 = 16'h0000;
    @(negedge clk);
    chk("s4_pre_rdy0", 32'(bus.rdy0), 32'h1);
    cyc();
    bus.v0 = 1'b1; bus.addr0 = 3'd5; bus.data0 = 16'h1111;
    bus.v1 = 1'b1; bus.addr1 = 3'd5; bus.data1 = 16'h2222;
    @(negedge clk);
    chk("s4_last", 32'(bus.last_gnt), 32'h0);
    chk("s4_rdy1a", 32'(bus.rdy1), 32'h1);
    chk("s4_rdy0a", 32'(bus.rdy0), 32'h0);
    cyc();
    bus.v1 = 1'b0;
    @(negedge clk);
    chk("s4_rdy0b", 32'(bus.rdy0), 32'h1);
    chk("s4_sel_b", 32'(bus.wr_sel), 32'h20);
    chk("s4_data_b", 32'(bus.wr_data), 32'h2222);
    cyc();
    bus.v0 = 1'b0;
    @(negedge clk);
    chk("s4_reg5_first", 32'(regs[5]), 32'h2222);
    chk("s4_data_c", 32'(bus.wr_data), 32'h1111);
    cyc();
    @(negedge clk);
    chk("s4_reg5_final", 32'(regs[5]), 32'h1111);

    // Clear in RUN with a pending request: refused, re-init, then accepted.
    cyc();
    bus.clr_req = 1'b1;
    bus.v0 = 1'b1; bus.addr0 = 3'd6; bus.data0 = 16'hCAFE;
    @(negedge clk);
    chk("s5_clr_rdy0", 32'(bus.rdy0), 32'h0);
    cyc();
    bus.clr_req = 1'b0;
    init_seq(1'b1);
    cyc();
    bus.v0 = 1'b0;
    @(negedge clk);
    chk("s5_reg3_zero", 32'(regs[3]), 32'h0);
    chk("s5_reg5_zero", 32'(regs[5]), 32'h0);
    chk("s5_sel", 32'(bus.wr_sel), 32'h40);
    chk("s5_data", 32'(bus.wr_data), 32'hCAFE);
    cyc();
    @(negedge clk);
    chk("s5_reg6", 32'(regs[6]), 32'hCAFE);

    // Reset while INIT is at cnt=4.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("s6_mid_sel", 32'(bus.wr_sel), 32'h08);
    cyc();
    rst = 1'b0;
    init_seq(1'b0);
    chk("s6a_last", 32'(bus.last_gnt), 32'h1);

    // Reset the cycle after a grant, with the requester still asserting valid.
    cyc();
    bus.v0 = 1'b1; bus.addr0 = 3'd2; bus.data0 = 16'h1234;
    @(negedge clk);
    chk("s6_gnt_rdy0", 32'(bus.rdy0), 32'h1);
    cyc();
    rst = 1'b1;
    bus.data0 = 16'h5678;
    @(negedge clk);
    chk("s6_rst_rdy0", 32'(bus.rdy0), 32'h0);
    chk("s6_gnt_sel", 32'(bus.wr_sel), 32'h04);
    chk("s6_gnt_last", 32'(bus.last_gnt), 32'h0);
    cyc();
    rst = 1'b0;
    bus.v0 = 1'b0;
    init_seq(1'b0);
    chk("s6b_last", 32'(bus.last_gnt), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
